// File: rtl/code_entry_if.sv
// Keypad-to-sequencer bundle for code_entry_ctrl.
// master = keypad side, slave = controller side.
interface code_entry_if #(
  parameter int unsigned CODE_LEN = 4
);
  localparam int DW = $clog2(CODE_LEN + 1);

  logic [3:0]    key;
  logic          key_valid;
  logic          seq;
  logic          enable;
  logic [DW-1:0] digit_count;
  logic          busy;
  logic          locked;

  modport master (
    output key, key_valid,
    input  seq, enable, digit_count, busy, locked
  );

  modport slave (
    input  key, key_valid,
    output seq, enable, digit_count, busy, locked
  );
endinterface

// File: rtl/code_entry_ctrl.sv
// Keypad code collector and enable/seq sequencer for the alarm FSM.
// Optional lockout after repeated failures: define CODE_ENTRY_LOCKOUT_EN.
module code_entry_ctrl #(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] CODE = 16'h1234,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000
) (
  input logic         clk,
  input logic         rst,
  code_entry_if.slave kp
);

  localparam int DW = $clog2(CODE_LEN + 1);
  localparam int BW = 4 * CODE_LEN;
  localparam logic [31:0]   TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] LEN     = DW'(CODE_LEN);

  typedef enum logic [2:0] {
    IDLE, COLLECT, CHECK, PULSE, LOCKOUT
  } state_t;

  state_t        state;
  logic [BW-1:0] buf_q;
  logic [31:0]   timer;
  logic [DW-1:0] cnt;
  logic          seq_q;
  logic          en_q;
  logic          busy_q;
  logic          lock_q;

  logic          is_digit;
  logic          is_clear;
  logic [DW-1:0] cnt_inc;
  logic [BW-1:0] buf_shift;

  assign is_digit = kp.key_valid && (kp.key <= 4'd9);
  assign is_clear = kp.key_valid && (kp.key > 4'd9);
  assign cnt_inc  = cnt + 1'b1;

  if (CODE_LEN == 1) begin : g_one
    assign buf_shift = kp.key;
  end else begin : g_many
    assign buf_shift = {buf_q[BW-5:0], kp.key};
  end

`ifdef CODE_ENTRY_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] FMAX    = FW'(MAX_FAILS);
  localparam logic [31:0]   LK_LAST = 32'(LOCKOUT_CYCLES - 1);

  logic [FW-1:0] fails;
  logic [FW-1:0] fails_inc;

  assign fails_inc = fails + 1'b1;
`else
  logic unused_cfg;

  assign unused_cfg = ^{MAX_FAILS[0], LOCKOUT_CYCLES[0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      buf_q  <= '0;
      timer  <= '0;
      cnt    <= '0;
      seq_q  <= 1'b0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      lock_q <= 1'b0;
`ifdef CODE_ENTRY_LOCKOUT_EN
      fails  <= '0;
`endif
    end else begin
      en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (is_digit) begin
            buf_q  <= buf_shift;
            cnt    <= DW'(1);
            timer  <= '0;
            busy_q <= 1'b1;
            state  <= (LEN == DW'(1)) ? CHECK : COLLECT;
          end
        end
        COLLECT: begin
          // a digit beats a simultaneous timeout
          if (is_digit) begin
            buf_q <= buf_shift;
            cnt   <= cnt_inc;
            timer <= '0;
            if (cnt_inc == LEN) state <= CHECK;
          end else if (is_clear || timer == TO_LAST) begin
            buf_q  <= '0;
            cnt    <= '0;
            timer  <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        CHECK: begin
          seq_q <= (buf_q == CODE);
          en_q  <= 1'b1;
          state <= PULSE;
        end
        PULSE: begin
          buf_q  <= '0;
          cnt    <= '0;
          timer  <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
`ifdef CODE_ENTRY_LOCKOUT_EN
          if (seq_q) begin
            fails <= '0;
          end else begin
            fails <= fails_inc;
            if (fails_inc == FMAX) begin
              lock_q <= 1'b1;
              state  <= LOCKOUT;
            end
          end
`endif
        end
`ifdef CODE_ENTRY_LOCKOUT_EN
        LOCKOUT: begin
          if (timer == LK_LAST) begin
            timer  <= '0;
            fails  <= '0;
            lock_q <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign kp.seq         = seq_q;
  assign kp.enable      = en_q;
  assign kp.digit_count = cnt;
  assign kp.busy        = busy_q;
  assign kp.locked      = lock_q;

endmodule
